// File: rtl/adder_pkg.sv
// Shared constants, stage register layout and configuration check for the adder family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Stage register layout at the default width; pipe_adder declares the
    // same field set sized to its own WIDTH parameter.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] opa;
        logic [DEF_WIDTH-1:0] opb;
    } stage_t;

    // Legal when the carry chain splits into equal, non-empty segments.
    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry segment: {c_o, s_o} = a_i + b_i + c_i.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline registers the result.
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    output logic [SEG-1:0] s_o,
    output logic           c_o
);

    logic [SEG:0] w_c;

    // Ripple the carry bit by bit through the segment.
    always_comb begin
        w_c    = '0;
        s_o    = '0;
        w_c[0] = c_i;
        for (int i = 0; i < SEG; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
            w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = w_c[SEG];
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder, carry chain cut into STAGES registered segments.
// Latency: STAGES cycles from acceptance to out_valid_o; one result per cycle.
// Backpressure: a stalled output freezes every stage; in_ready_o drops with it.
// Optional macro PIPE_ADDER_OVF_EN adds the registered signed-overflow output ovf_o.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipe_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
    } stg_t;

    logic w_adv;

    // Whole pipe moves together; no bubble collapsing.
    assign w_adv      = !out_valid_o || out_ready_i;
    assign in_ready_o = rst_n_i && w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stg_t             r_stg;
        logic             w_vld;
        logic             w_cin;
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_sum_in;
        logic [WIDTH-1:0] w_sum;
        logic [SEG-1:0]   w_seg_s;
        logic             w_seg_c;

        if (k == 0) begin : g_first
            assign w_vld    = in_valid_i;
            assign w_cin    = C_i;
            assign w_a      = A_i;
            assign w_b      = B_i;
            assign w_sum_in = '0;
        end else begin : g_next
            assign w_vld    = g_stage[k-1].r_stg.valid;
            assign w_cin    = g_stage[k-1].r_stg.carry;
            assign w_a      = g_stage[k-1].r_stg.opa;
            assign w_b      = g_stage[k-1].r_stg.opb;
            assign w_sum_in = g_stage[k-1].r_stg.sum;
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a_i (w_a[k*SEG +: SEG]),
            .b_i (w_b[k*SEG +: SEG]),
            .c_i (w_cin),
            .s_o (w_seg_s),
            .c_o (w_seg_c)
        );

        // Splice this segment's sum bits over the partial sum from upstream.
        always_comb begin
            w_sum               = w_sum_in;
            w_sum[k*SEG +: SEG] = w_seg_s;
        end

        // Stage register: cleared by reset, loads only when the pipe advances.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                r_stg <= '0;
            end else if (w_adv) begin
                r_stg <= '{valid: w_vld, carry: w_seg_c, sum: w_sum, opa: w_a, opb: w_b};
            end
        end
    end

    assign out_valid_o = g_stage[LAST].r_stg.valid;
    assign S_o         = g_stage[LAST].r_stg.sum;
    assign C_o         = g_stage[LAST].r_stg.carry;

    // Operands leaving the final stage have no further consumer.
    logic w_unused_ops;
    assign w_unused_ops = ^{g_stage[LAST].r_stg.opa, g_stage[LAST].r_stg.opb};

`ifdef PIPE_ADDER_OVF_EN
    logic w_ovf_nxt;
    logic r_ovf;

    // Sign bits reach the last segment through the forwarded operands.
    assign w_ovf_nxt = (g_stage[LAST].w_a[WIDTH-1] == g_stage[LAST].w_b[WIDTH-1]) &&
                       (g_stage[LAST].w_sum[WIDTH-1] != g_stage[LAST].w_a[WIDTH-1]);

    // Overflow flag registered alongside the final stage.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed vectors on a STAGES=2 instance plus
// a random-ready sweep over STAGES 1/4/8 instances.
// Drivers push expected results; negedge monitors pop and compare on each transfer.
`timescale 1ns/1ps
module tb_pipe_adder;

    localparam int W = 8;

    typedef struct packed {
        logic         c;
        logic [W-1:0] s;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         o_vld;
    logic         o_rdy;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         sweep_go;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (2)
    ) u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_vld),
        .in_ready_o  (in_rdy),
        .A_i         (a),
        .B_i         (b),
        .C_i         (ci),
        .out_valid_o (o_vld),
        .out_ready_i (o_rdy),
        .S_o         (s),
        .C_o         (co)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] t;
        exp_t       e;
        t     = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        e.c   = t[W];
        e.s   = t[W-1:0];
        e.ovf = (av[W-1] == bv[W-1]) && (t[W-1] != av[W-1]);
        return e;
    endfunction

    // Present one operand set with its hand-computed result; waits for acceptance.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec, input logic eo);
        bit   ok;
        exp_t e;
        a      = av;
        b      = bv;
        ci     = cv;
        in_vld = 1'b1;
        ok     = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_rdy;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready_o stayed 0 for A=0x%0h B=0x%0h", av, bv);
        end else begin
            e = '{c: ec, s: es, ovf: eo};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    // Main monitor: every output transfer must match the queue head.
    always @(negedge clk) begin
        if (rst_n && o_vld && o_rdy) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: S=0x%0h C=%0d with empty scoreboard", s, co);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_sum", 32'(s), 32'(e.s));
                check("out_cout", 32'(co), 32'(e.c));
`ifdef PIPE_ADDER_OVF_EN
                check("out_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Sweep instances at other depths, each with its own driver, ready source and monitor.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);

        logic         sv;
        logic         srdy;
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic         sc;
        logic         sov;
        logic         sordy;
        logic [W-1:0] ss;
        logic         sco;
        logic         sovf;
        bit           done;
        exp_t         sq[$];

        pipe_adder #(
            .WIDTH  (W),
            .STAGES (ST)
        ) u_sw (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .in_valid_i  (sv),
            .in_ready_o  (srdy),
            .A_i         (sa),
            .B_i         (sb),
            .C_i         (sc),
            .out_valid_o (sov),
            .out_ready_i (sordy),
            .S_o         (ss),
            .C_o         (sco)
`ifdef PIPE_ADDER_OVF_EN
            ,
            .ovf_o       (sovf)
`endif
        );

`ifndef PIPE_ADDER_OVF_EN
        assign sovf = 1'b0;
`endif

        initial begin
            sordy = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                sordy = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin
            bit ok;
            sv   = 1'b0;
            sa   = '0;
            sb   = '0;
            sc   = 1'b0;
            done = 1'b0;
            wait (sweep_go);
            @(posedge clk);
            #1;
            for (int n = 0; n < 30; n++) begin
                sa = W'($urandom);
                sb = W'($urandom);
                sc = 1'($urandom_range(0, 1));
                sv = ($urandom_range(0, 4) != 0);
                ok = 1'b0;
                for (int t = 0; t < 200 && !ok; t++) begin
                    @(negedge clk);
                    ok = srdy && sv;
                    if (!sv) break;
                end
                if (sv && !ok) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sw%0d_send_timeout: in_ready_o stuck low", ST);
                end else if (ok) begin
                    sq.push_back(model(sa, sb, sc));
                end
                @(posedge clk);
                #1;
                sv = 1'b0;
            end
            for (int t = 0; t < 500 && sq.size() != 0; t++) @(negedge clk);
            check($sformatf("sw%0d_drained", ST), 32'(sq.size()), 32'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (rst_n && sov && sordy) begin
                if (sq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sw%0d_unexpected_out: S=0x%0h with empty scoreboard", ST, ss);
                end else begin
                    exp_t e;
                    e = sq.pop_front();
                    check($sformatf("sw%0d_sum", ST), 32'(ss), 32'(e.s));
                    check($sformatf("sw%0d_cout", ST), 32'(sco), 32'(e.c));
`ifdef PIPE_ADDER_OVF_EN
                    check($sformatf("sw%0d_ovf", ST), 32'(sovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence, then the sweep.
    initial begin
        rst_n    = 1'b0;
        in_vld   = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;
        o_rdy    = 1'b1;
        sweep_go = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready_low", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(o_vld), 32'd0);
        check("rst_sum", 32'(s), 32'd0);
        check("rst_cout", 32'(co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready_high", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Latency: 0xFF + 0x01 valid exactly two edges after acceptance
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("lat_not_early", 32'(o_vld), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(o_vld), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back inputs; results must come out on consecutive cycles
        send(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("b2b_valid_2", 32'(o_vld), 32'd1);
        @(negedge clk);
        check("b2b_valid_3", 32'(o_vld), 32'd1);
        @(negedge clk);
        check("b2b_empty", 32'(o_vld), 32'd0);
`ifdef PIPE_ADDER_OVF_EN
        @(posedge clk);
        #1;
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
`endif
        @(posedge clk);
        #1;

        // Stall with a full pipe: outputs hold, input blocked, then drain in order
        o_rdy = 1'b0;
        send(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        send(8'hA0, 8'h70, 1'b1, 8'h11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_rdy), 32'd0);
            check("stall_valid", 32'(o_vld), 32'd1);
            check("stall_sum_hold", 32'(s), 32'h46);
            check("stall_cout_hold", 32'(co), 32'd0);
        end
        @(posedge clk);
        #1;
        o_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("stall_drained", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset with two items in flight: both discarded
        o_rdy = 1'b0;
        send(8'h55, 8'h55, 1'b0, 8'hAA, 1'b0, 1'b1);
        send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrst_in_ready", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(o_vld), 32'd0);
        check("midrst_sum", 32'(s), 32'd0);
        check("midrst_cout", 32'(co), 32'd0);
        @(posedge clk);
        #1;
        o_rdy = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_stale", 32'(o_vld), 32'd0);
        @(posedge clk);
        #1;

        // Random out_ready with a directed vector table
        fork
            begin
                send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
                send(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);
                send(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
                send(8'hFE, 8'hFE, 1'b1, 8'hFD, 1'b1, 1'b0);
                send(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
                send(8'h81, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1);
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    o_rdy = 1'($urandom_range(0, 1));
                end
                o_rdy = 1'b1;
            end
        join
        for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
        check("rr_drained", 32'(q.size()), 32'd0);

        // Sweep over other depths
        sweep_go = 1'b1;
        for (int t = 0; t < 20000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); t++)
            @(negedge clk);
        check("sweep_done", 32'(g_sw[0].done && g_sw[1].done && g_sw[2].done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
